// File: rtl/pkt_ctrl_pkg.sv
// Shared types and defaults for the packet transaction controller.
package pkt_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, READ, PROC, WRITE} pkt_state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_PROC_CYCLES = 3;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_CNT_W       = 16;

  // Bits needed to hold 0..n-1; never below 1.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pkt_ctrl_mc_arb.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module pkt_rr_arb
  import pkt_ctrl_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IDX_W = clog2w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    if (en) begin
      for (int i = 1; i <= N_CH; i++) begin
        j = (int'(ptr) + i) % N_CH;
        if (!vld && req[j]) begin
          vld    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pkt_ctrl_mc.sv
// Multi-channel READ->PROC->WRITE packet controller with round-robin grant.
// Optional READ abort on stall is enabled by defining PKT_CTRL_TIMEOUT_EN.
module pkt_ctrl_mc
  import pkt_ctrl_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int PROC_CYCLES = DEF_PROC_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic                    rd_ctrl,
  input  logic                    rd_valid,
  output logic                    wr_ctrl,
  input  logic                    wr_ready,
  output logic                    commit,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [CNT_W-1:0]        pkt_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int PC_W  = clog2w(PROC_CYCLES);

  pkt_state_t       state_q, state_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] active_q, active_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;

  logic [N_CH-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  pkt_rr_arb #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (state_q == IDLE),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

`ifdef PKT_CTRL_TIMEOUT_EN
  localparam int WAIT_W = clog2w(TIMEOUT);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              terr_q, terr_d;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    pc_d     = pc_q;
    pkt_d    = pkt_q;
`ifdef PKT_CTRL_TIMEOUT_EN
    wait_d   = '0;
    drop_d   = drop_q;
    terr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d  = READ;
          grant_d  = arb_gnt;
          active_d = arb_idx;
          ptr_d    = arb_idx;
        end
      end
      READ: begin
        // rd_valid takes priority over an expiring wait
        if (rd_valid) begin
          state_d = PROC;
          pc_d    = PC_W'(PROC_CYCLES - 1);
        end
`ifdef PKT_CTRL_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          terr_d  = 1'b1;
          drop_d  = (drop_q == '1) ? drop_q : drop_q + CNT_W'(1);
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      PROC: begin
        if (pc_q == '0) state_d = WRITE;
        else            pc_d    = pc_q - PC_W'(1);
      end
      WRITE: begin
        if (wr_ready) begin
          state_d = IDLE;
          grant_d = '0;
          pkt_d   = (pkt_q == '1) ? pkt_q : pkt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      active_q <= '0;
      ptr_q    <= IDX_W'(N_CH - 1);
      pc_q     <= '0;
      pkt_q    <= '0;
`ifdef PKT_CTRL_TIMEOUT_EN
      wait_q   <= '0;
      drop_q   <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      pc_q     <= pc_d;
      pkt_q    <= pkt_d;
`ifdef PKT_CTRL_TIMEOUT_EN
      wait_q   <= wait_d;
      drop_q   <= drop_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign active_ch = active_q;
  assign rd_ctrl   = (state_q == READ);
  assign wr_ctrl   = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign commit    = wr_ctrl & wr_ready;
  assign pkt_count = pkt_q;

`ifdef PKT_CTRL_TIMEOUT_EN
  assign timeout_err = terr_q;
  assign drop_count  = drop_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT > 0);
  assign timeout_err = 1'b0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_pkt_ctrl_mc.sv
// Directed bench for pkt_ctrl_mc; CNT_W=2 so saturation shows within a few packets.
module tb_pkt_ctrl_mc;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] active_ch;
  logic       rd_ctrl, rd_valid, wr_ctrl, wr_ready, commit, busy, timeout_err;
  logic [1:0] pkt_count, drop_count;

  int total = 0;
  int bad   = 0;

  pkt_ctrl_mc #(.N_CH(4), .PROC_CYCLES(3), .TIMEOUT(8), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .active_ch   (active_ch),
    .rd_ctrl     (rd_ctrl),
    .rd_valid    (rd_valid),
    .wr_ctrl     (wr_ctrl),
    .wr_ready    (wr_ready),
    .commit      (commit),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; rd_valid = 1'b0; wr_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int n, wc, cc;
    reset = 1'b1; req = '0; rd_valid = 1'b0; wr_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(rd_ctrl), 0);
    chk("rst_wr", 32'(wr_ctrl), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_terr", 32'(timeout_err), 0);

    // single channel, slow rd_valid, mid-transaction req drop
    do_reset();
    req = 4'b0100; wr_ready = 1'b1;
    step();
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_active", 32'(active_ch), 2);
    chk("t1_rd", 32'(rd_ctrl), 1);
    step();
    chk("t1_rd_wait", 32'(rd_ctrl), 1);
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0; req = '0;
    n = 0;
    while (busy && !wr_ctrl && !rd_ctrl && n < 10) begin
      n++;
      step();
    end
    chk("t1_proc_len", 32'(n), 3);
    chk("t1_wr", 32'(wr_ctrl), 1);
    chk("t1_commit", 32'(commit), 1);
    chk("t1_grant_hold", 32'(grant), 32'h4);
    step();
    chk("t1_commit_off", 32'(commit), 0);
    chk("t1_pkt", 32'(pkt_count), 1);
    chk("t1_grant_clr", 32'(grant), 0);
    chk("t1_idle", 32'(busy), 0);

    // write backpressure: 10 stalled cycles then accept
    do_reset();
    req = 4'b0010; rd_valid = 1'b1; wr_ready = 1'b0;
    step();
    chk("t3_grant", 32'(grant), 32'h2);
    repeat (4) step();
    chk("t3_wr", 32'(wr_ctrl), 1);
    wc = 0; cc = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) wr_ready = 1'b1;
      #1;
      wc += int'(wr_ctrl);
      cc += int'(commit);
      step();
    end
    chk("t3_wr_cycles", 32'(wc), 11);
    chk("t3_commits", 32'(cc), 1);
    chk("t3_pkt", 32'(pkt_count), 1);
    req = '0;

    // round robin with everything ready; counter saturates at 3
    do_reset();
    req = 4'b1111; rd_valid = 1'b1; wr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_grant", 32'(grant), 32'(1 << (k % 4)));
      repeat (4) step();
      chk("t2_commit", 32'(commit), 1);
      step();
      chk("t2_idle", 32'(busy), 0);
      chk("t2_pkt", 32'(pkt_count), (k < 3) ? 32'(k + 1) : 3);
    end
    req = '0;

    // async reset mid-PROC
    req = 4'b0001;
    step(); step(); step();
    chk("t5_in_proc", 32'(busy & ~rd_ctrl & ~wr_ctrl), 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_grant", 32'(grant), 0);
    chk("t5_pkt", 32'(pkt_count), 0);
    chk("t5_rd", 32'(rd_ctrl), 0);
    chk("t5_commit", 32'(commit), 0);
    step();
    reset = 1'b1; req = '0;
    step();

`ifdef PKT_CTRL_TIMEOUT_EN
    // READ abort after 8 cycles, then rd_valid on the expiry cycle
    do_reset();
    req = 4'b0101; rd_valid = 1'b0;
    step();
    chk("t4_grant", 32'(grant), 32'h1);
    repeat (7) step();
    chk("t4_still_rd", 32'(rd_ctrl), 1);
    chk("t4_no_terr", 32'(timeout_err), 0);
    step();
    chk("t4_terr", 32'(timeout_err), 1);
    chk("t4_drop", 32'(drop_count), 1);
    chk("t4_grant_clr", 32'(grant), 0);
    step();
    chk("t4_terr_pulse", 32'(timeout_err), 0);
    chk("t4_next", 32'(grant), 32'h4);
    repeat (7) step();
    rd_valid = 1'b1;
    step();
    chk("t6_proc", 32'(busy & ~rd_ctrl & ~wr_ctrl), 1);
    chk("t6_terr", 32'(timeout_err), 0);
    chk("t6_drop", 32'(drop_count), 1);
    rd_valid = 1'b0; wr_ready = 1'b1; req = '0;
    repeat (3) step();
    chk("t6_commit", 32'(commit), 1);
    step();
    chk("t6_pkt", 32'(pkt_count), 1);
`else
    // without the timeout feature READ waits forever
    do_reset();
    req = 4'b0001; rd_valid = 1'b0;
    repeat (21) step();
    chk("nt_rd_hold", 32'(rd_ctrl), 1);
    chk("nt_terr", 32'(timeout_err), 0);
    chk("nt_drop", 32'(drop_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
